// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered hex value, per-digit
// dwell with an optional all-off guard interval, and leading-zero blanking.
module ssd_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_en,
  input  logic                    lzb_en,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic                    drv_enable,
  output logic [3:0]              drv_binary,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GUARD
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic                    drv_enable_q, drv_enable_d;
  logic [3:0]              drv_binary_q, drv_binary_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    frame_start;
  logic                    advance;
  logic                    seen_nonzero;
  logic [NUM_DIGITS-1:0]   lead_zero;

  always_comb begin
    state_d         = state_q;
    digit_d         = digit_q;
    cnt_d           = cnt_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    frame_start     = 1'b0;
    frame_done_d    = 1'b0;
    advance         = 1'b0;

    if (!disp_en) begin
      state_d = IDLE;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SHOW;
          digit_d     = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d = '0;
            if (GUARD_CYCLES > 0) state_d = GUARD;
            else                  advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Wrapping past the last digit is the only frame start that reports frame_done
      if (advance) begin
        if (digit_q == DIGIT_LAST) begin
          digit_d      = '0;
          frame_start  = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          digit_d = digit_q + 1'b1;
        end
      end
    end

    // A load accepted this cycle implies pending was empty, so it never races the transfer
    if (frame_start && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
    end
    if (load_valid && !pending_valid_q) begin
      pending_d       = load_data;
      pending_valid_d = 1'b1;
    end

    seen_nonzero = 1'b0;
    lead_zero    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      seen_nonzero = seen_nonzero || (active_d[4*(NUM_DIGITS-1-i) +: 4] != 4'h0);
      lead_zero[NUM_DIGITS-1-i] = !seen_nonzero;
    end

    digit_en_d   = '0;
    drv_binary_d = '0;
    drv_enable_d = 1'b0;
    if (state_d == SHOW) begin
      digit_en_d   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_d;
      drv_binary_d = active_d[4*digit_d +: 4];
      drv_enable_d = !(lzb_en && (digit_d != '0) && lead_zero[digit_d]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      digit_q         <= '0;
      cnt_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      drv_enable_q    <= 1'b0;
      drv_binary_q    <= '0;
      digit_en_q      <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      digit_q         <= digit_d;
      cnt_q           <= cnt_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      drv_enable_q    <= drv_enable_d;
      drv_binary_q    <= drv_binary_d;
      digit_en_q      <= digit_en_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign load_ready = !pending_valid_q;
  assign drv_enable = drv_enable_q;
  assign drv_binary = drv_binary_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: two configurations (with and without guard) share stimulus
// and are compared each cycle against a timeline-based reference model.
module tb_ssd_scan_ctrl;

  localparam int unsigned ND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_en = 1'b0;
  logic        lzb_en = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;

  logic       load_ready_a, drv_enable_a, frame_done_a;
  logic [3:0] drv_binary_a, digit_en_a;
  logic       load_ready_b, drv_enable_b, frame_done_b;
  logic [3:0] drv_binary_b, digit_en_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .lzb_en(lzb_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready_a),
    .drv_enable(drv_enable_a), .drv_binary(drv_binary_a), .digit_en(digit_en_a),
    .frame_done(frame_done_a)
  );

  ssd_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(3), .GUARD_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .lzb_en(lzb_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready_b),
    .drv_enable(drv_enable_b), .drv_binary(drv_binary_b), .digit_en(digit_en_b),
    .frame_done(frame_done_b)
  );

  logic [10:0] obs_a, obs_b;
  assign obs_a = {frame_done_a, drv_enable_a, drv_binary_a, digit_en_a, load_ready_a};
  assign obs_b = {frame_done_b, drv_enable_b, drv_binary_b, digit_en_b, load_ready_b};

  // Reference model: position in the frame is elapsed enabled time modulo the frame period
  int unsigned m_show [2] = '{4, 3};
  int unsigned m_slot [2] = '{5, 3};
  int unsigned m_t    [2];
  bit          m_run  [2];
  bit          m_pv   [2];
  logic [15:0] m_act  [2];
  logic [15:0] m_pend [2];
  logic [10:0] exp_o  [2];

  initial begin : model
    bit          fs, acc, blank;
    int unsigned p, d;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_t[k] = 0; m_run[k] = 0; m_pv[k] = 0;
          m_act[k] = '0; m_pend[k] = '0;
          exp_o[k] = 11'h001;
        end else begin
          acc = load_valid && !m_pv[k];
          fs  = 1'b0;
          if (!disp_en) m_run[k] = 1'b0;
          else begin
            if (m_run[k]) m_t[k]++;
            else begin m_run[k] = 1'b1; m_t[k] = 0; end
            fs = (m_t[k] % (ND * m_slot[k])) == 0;
          end
          if (fs && m_pv[k]) begin m_act[k] = m_pend[k]; m_pv[k] = 1'b0; end
          if (acc) begin m_pend[k] = load_data; m_pv[k] = 1'b1; end
          exp_o[k] = {10'b0, !m_pv[k]};
          if (m_run[k]) begin
            p = m_t[k] % (ND * m_slot[k]);
            d = p / m_slot[k];
            if ((p % m_slot[k]) < m_show[k]) begin
              blank = lzb_en && (d > 0) && ((m_act[k] >> (4 * d)) == 16'h0);
              exp_o[k][9]   = !blank;
              exp_o[k][8:5] = 4'(m_act[k] >> (4 * d));
              exp_o[k][4:1] = 4'(1 << d);
            end
            exp_o[k][10] = fs && (m_t[k] > 0);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; disp_en = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs_a !== 11'h001) begin bad++; $display("FAIL reset_a got=%h want=%h", obs_a, 11'h001); end
    total++;
    if (obs_b !== 11'h001) begin bad++; $display("FAIL reset_b got=%h want=%h", obs_b, 11'h001); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int fd = 0;
    @(negedge clk); load_valid = 1'b1; load_data = 16'h12AF;
    @(negedge clk); load_valid = 1'b0;
    total++;
    if (load_ready_a !== 1'b0) begin bad++; $display("FAIL scan_accept got=%b want=0", load_ready_a); end
    disp_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      total++;
      if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
        bad++; $display("FAIL model_scan i=%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, exp_o[0], exp_o[1]);
      end
      if (i == 0) begin
        total++;
        if (obs_a !== {1'b0, 1'b1, 4'hF, 4'b0001, 1'b1}) begin bad++; $display("FAIL scan_first got=%h want=%h", obs_a, {1'b0, 1'b1, 4'hF, 4'b0001, 1'b1}); end
      end
      if (i == 4) begin
        total++;
        if (obs_a[10:1] !== 10'h0) begin bad++; $display("FAIL scan_guard got=%h want=000", obs_a[10:1]); end
      end
      if (i == 5) begin
        total++;
        if (obs_a[8:1] !== 8'hA2) begin bad++; $display("FAIL scan_digit1 got=%h want=a2", obs_a[8:1]); end
      end
      if (frame_done_a) fd++;
    end
    total++;
    if (fd != 2) begin bad++; $display("FAIL scan_frame_done got=%0d want=2", fd); end
  endtask

  task automatic test_handshake();
    int fdn = 0;
    bit taken2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
        bad++; $display("FAIL model_hs_pre i=%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, exp_o[0], exp_o[1]);
      end
    end
    @(negedge clk); load_valid = 1'b1; load_data = 16'h1111;
    @(negedge clk); load_data = 16'h2222;
    total++;
    if (load_ready_a !== 1'b0) begin bad++; $display("FAIL hs_ready_drop got=%b want=0", load_ready_a); end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
        bad++; $display("FAIL model_hs i=%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, exp_o[0], exp_o[1]);
      end
      if (frame_done_a) begin
        fdn++;
        total++;
        if (drv_binary_a !== ((fdn == 1) ? 4'h1 : 4'h2)) begin
          bad++; $display("FAIL hs_frame%0d got=%h want=%h", fdn, drv_binary_a, (fdn == 1) ? 4'h1 : 4'h2);
        end
      end
      if (taken2) load_valid = 1'b0;
      if (load_valid && load_ready_a) taken2 = 1'b1;
    end
    total++;
    if (fdn != 2) begin bad++; $display("FAIL hs_frames got=%0d want=2", fdn); end
    load_valid = 1'b0;
  endtask

  task automatic test_simul_load();
    bit hit = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      total++;
      if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
        bad++; $display("FAIL model_sim_wait got=%h/%h want=%h/%h", obs_a, obs_b, exp_o[0], exp_o[1]);
      end
      if (m_run[0] && !m_pv[0] && (m_t[0] % 20) == 19) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL sim_wait got=timeout want=frame_edge"); return; end
    load_valid = 1'b1; load_data = 16'h9876;
    @(negedge clk); load_valid = 1'b0;
    total++;
    if ({load_ready_a, drv_binary_a, frame_done_a} !== {1'b0, 4'h2, 1'b1}) begin
      bad++; $display("FAIL sim_same_frame got=%b/%h/%b want=0/2/1", load_ready_a, drv_binary_a, frame_done_a);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
        bad++; $display("FAIL model_sim i=%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, exp_o[0], exp_o[1]);
      end
    end
    total++;
    if ({load_ready_a, drv_binary_a, frame_done_a} !== {1'b1, 4'h6, 1'b1}) begin
      bad++; $display("FAIL sim_next_frame got=%b/%h/%b want=1/6/1", load_ready_a, drv_binary_a, frame_done_a);
    end
  endtask

  task automatic test_lzb();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    bit          armed;
    logic        want_en;
    logic [3:0]  want_bin;
    lzb_en = 1'b1;
    foreach (vals[v]) begin
      armed = 1'b0;
      @(negedge clk); load_valid = 1'b1; load_data = vals[v];
      @(negedge clk); load_valid = 1'b0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clk);
        total++;
        if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
          bad++; $display("FAIL model_lzb i=%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, exp_o[0], exp_o[1]);
        end
        if (frame_done_a) armed = 1'b1;
        if (armed && digit_en_a != 4'b0000) begin
          want_en  = (digit_en_a == 4'b0001) || (vals[v] == 16'h0050 && digit_en_a == 4'b0010);
          want_bin = (vals[v] == 16'h0050 && digit_en_a == 4'b0010) ? 4'h5 : 4'h0;
          total++;
          if ({drv_enable_a, drv_binary_a} !== {want_en, want_bin}) begin
            bad++; $display("FAIL lzb_%h sel=%b got=%b/%h want=%b/%h", vals[v], digit_en_a, drv_enable_a, drv_binary_a, want_en, want_bin);
          end
        end
      end
    end
  endtask

  task automatic test_disable();
    bit hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (digit_en_b === 4'b0000) begin bad++; $display("FAIL noguard_dark i=%0d got=%b want=nonzero", i, digit_en_b); end
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (digit_en_a != 4'b0000) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL dis_wait got=timeout want=show"); return; end
    disp_en = 1'b0;
    @(negedge clk);
    total++;
    if ({obs_a[10:1], obs_b[10:1]} !== 20'h0) begin
      bad++; $display("FAIL dis_off got=%h/%h want=000/000", obs_a[10:1], obs_b[10:1]);
    end
    disp_en = 1'b1;
    @(negedge clk);
    total++;
    if ({frame_done_a, digit_en_a, frame_done_b, digit_en_b} !== {1'b0, 4'b0001, 1'b0, 4'b0001}) begin
      bad++; $display("FAIL dis_restart got=%b%b/%b%b want=00001/00001", frame_done_a, digit_en_a, frame_done_b, digit_en_b);
    end
    total++;
    if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
      bad++; $display("FAIL model_dis got=%h/%h want=%h/%h", obs_a, obs_b, exp_o[0], exp_o[1]);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit hit = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (digit_en_a == 4'b0100) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rst_wait got=timeout want=digit2"); return; end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({obs_a, obs_b} !== {11'h001, 11'h001}) begin
      bad++; $display("FAIL rst_mid got=%h/%h want=001/001", obs_a, obs_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs_a !== {1'b0, 1'b1, 4'h0, 4'b0001, 1'b1}) begin
      bad++; $display("FAIL rst_restart got=%h want=%h", obs_a, {1'b0, 1'b1, 4'h0, 4'b0001, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      total++;
      if ({obs_a, obs_b} !== {exp_o[0], exp_o[1]}) begin
        bad++; $display("FAIL model_rand i=%0d got=%h/%h want=%h/%h", i, obs_a, obs_b, exp_o[0], exp_o[1]);
      end
      disp_en    = ($urandom_range(0, 49) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
      for (int j = 0; j < 4; j++)
        load_data[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_simul_load();
    test_lzb();
    test_disable();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
